// File: rtl/cf_fft_1024_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cf_fft_1024_ctrl
// Brief    : Stage/butterfly sequencer for an in-place radix-2 DIT 1024-pt FFT
// Revision : 1.0 - initial release
// ============================================================================
module cf_fft_1024_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int BF_LAT  = 4
) (
  input  logic       clock_c,
  input  logic       reset_c,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] stage,
  output logic       rd_en,
  output logic [9:0] rd_addr_a,
  output logic [9:0] rd_addr_b,
  output logic [5:0] tw_idx,
  output logic       bf_en,
  output logic       wr_en,
  output logic [9:0] wr_addr_a,
  output logic [9:0] wr_addr_b
);

  localparam int         c_WB_LAT     = MEM_LAT + BF_LAT;
  localparam logic [3:0] c_LAST_STAGE = 4'd9;
  localparam logic [3:0] c_DRAIN_LAST = 4'(c_WB_LAT - 1);
  localparam logic [8:0] c_LAST_J     = 9'd511;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [8:0] r_j, w_j_nxt;
  logic [3:0] r_stage, w_stage_nxt;
  logic [3:0] r_dcnt, w_dcnt_nxt;

  always_ff @(posedge clock_c) begin
    if (reset_c) begin
      r_state <= S_IDLE;
      r_j     <= '0;
      r_stage <= '0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_j     <= w_j_nxt;
      r_stage <= w_stage_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_j_nxt     = r_j;
    w_stage_nxt = r_stage;
    w_dcnt_nxt  = r_dcnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_j_nxt     = '0;
          w_stage_nxt = '0;
        end
      end
      S_RUN: begin
        w_dcnt_nxt = '0;
        w_j_nxt    = r_j + 9'd1;
        if (r_j == c_LAST_J) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_dcnt_nxt = r_dcnt + 4'd1;
        // The last write of this stage lands in the final drain cycle.
        if (r_dcnt == c_DRAIN_LAST) begin
          w_dcnt_nxt = '0;
          if (r_stage == c_LAST_STAGE) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RUN;
            w_stage_nxt = r_stage + 4'd1;
            w_j_nxt     = '0;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_stage_nxt = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  logic       w_issue;
  logic [9:0] w_half;
  logic [8:0] w_mask;
  logic [9:0] w_j10;
  logic [8:0] w_p;
  logic [8:0] w_e;
  logic [9:0] w_addr_a;
  logic [9:0] w_addr_b;
  logic [5:0] w_tw;

  always_comb begin
    w_issue  = (r_state == S_RUN);
    w_half   = 10'd1 << r_stage;
    w_mask   = 9'(w_half - 10'd1);
    w_j10    = {1'b0, r_j};
    w_p      = r_j & w_mask;
    // Twiddle exponent scaled to the 1024-point circle, then truncated to the ROM grid.
    w_e      = w_p << (4'd9 - r_stage);
    w_tw     = 6'(w_e >> 3);
    w_addr_a = ((w_j10 >> r_stage) << (r_stage + 4'd1)) | {1'b0, w_p};
    w_addr_b = w_addr_a | w_half;
    if (!w_issue) begin
      w_addr_a = '0;
      w_addr_b = '0;
      w_tw     = '0;
    end
  end

  logic [c_WB_LAT-1:0] r_wv;
  logic [9:0]          r_wa [c_WB_LAT];
  logic [9:0]          r_wb [c_WB_LAT];
  logic [5:0]          r_tw [MEM_LAT];

  always_ff @(posedge clock_c) begin
    if (reset_c) begin
      r_wv <= '0;
      for (int i = 0; i < c_WB_LAT; i++) begin
        r_wa[i] <= '0;
        r_wb[i] <= '0;
      end
      for (int i = 0; i < MEM_LAT; i++) begin
        r_tw[i] <= '0;
      end
    end else begin
      r_wv    <= {r_wv[c_WB_LAT-2:0], w_issue};
      r_wa[0] <= w_addr_a;
      r_wb[0] <= w_addr_b;
      for (int i = 1; i < c_WB_LAT; i++) begin
        r_wa[i] <= r_wa[i-1];
        r_wb[i] <= r_wb[i-1];
      end
      r_tw[0] <= w_tw;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_tw[i] <= r_tw[i-1];
      end
    end
  end

  always_comb begin
    busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    done      = (r_state == S_DONE);
    stage     = busy ? r_stage : 4'd0;
    bf_en     = busy;
    rd_en     = w_issue;
    rd_addr_a = w_addr_a;
    rd_addr_b = w_addr_b;
    tw_idx    = r_tw[MEM_LAT-1];
    wr_en     = r_wv[c_WB_LAT-1];
    wr_addr_a = wr_en ? r_wa[c_WB_LAT-1] : 10'd0;
    wr_addr_b = wr_en ? r_wb[c_WB_LAT-1] : 10'd0;
  end

endmodule
`default_nettype wire
